ysyx_24080014_mdu: RTL and testbench
====================================

# ysyx_24080014_mdu

Iterative RV32M multiply/divide unit on the execute side of the general register file. Consumes `rs1_data`/`rs2_data` plus a funct3 op. Computes over 32 cycles, with one-cycle fast paths for divide special cases. Holds the result until write-back takes it, and returns `rd_data` with its `rd` index for the register-file write port. The control unit stalls PC update while `busy` is high.

## Interface
- `XLEN`, 32: operand/result width; only 32 supported.
- `clk` input 1: sole clock, all state on posedge.
- `rst_n` input 1: synchronous, active-low reset.
- `in_valid` input 1: request present.
- `in_ready` output 1: unit can accept a request.
- `op` input 3: funct3; 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `rs1_data` input 32: operand A.
- `rs2_data` input 32: operand B.
- `rd_in` input 5: destination index.
- `flush` input 1: synchronous kill of in-flight op (trap/ecall/mret redirect).
- `out_valid` output 1: result available.
- `out_ready` input 1: write-back consumes the result.
- `rd_data` output 32: result.
- `rd_out` output 5: destination index.
- `busy` output 1: high in CALC or DONE.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`, latch op, operands, `rd_in`; clear the 6-bit counter.
  - Go to DONE if the op is a divide special case, otherwise CALC.
- CALC:
  - One iteration per cycle; after the 32nd iteration go to DONE.
  - `in_ready`=0.
- DONE:
  - `out_valid`=1; `rd_data`/`rd_out` stable.
  - On `out_ready`, go to IDLE.
- Multiply:
  - Radix-2 shift-add on 32-bit magnitudes, 64-bit accumulator.
  - Signedness: MULH both signed, MULHSU A signed only, MUL/MULHU unsigned.
  - Final product negated if the sign flags differ.
  - MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32].
- Divide:
  - Restoring divide on magnitudes; 33-bit partial remainder.
  - DIV/REM take signed magnitudes. Quotient negated if the signs differ; remainder takes the dividend's sign.
- Special cases (fast path, no CALC):
  - Divisor 0: DIV/DIVU→32'hFFFF_FFFF; REM/REMU→dividend.
  - DIV 32'h8000_0000 / 32'hFFFF_FFFF → 32'h8000_0000. REM with the same operands → 0.
- `rd_out`=0: computation still runs and the result is still presented. The register file discards the write.
- `flush`:
  - In any state, go to IDLE next edge; drop `out_valid`; no result issued.
  - `flush` wins over a simultaneous `in_valid` or `out_ready`.
- Reset (`rst_n`=0 at posedge, any state):
  - State IDLE; counter 0.
  - `out_valid`=0, `rd_data`=0, `rd_out`=0, `busy`=0, `in_ready`=1 after the edge.
- `in_valid` outside IDLE is ignored; the requester must hold it until `in_ready`.

## Timing
- Accept edge E0. CALC spans edges E1..E32. `out_valid` is high after E32, so latency is 32 cycles.
- Fast path: `out_valid` high after E0, so latency is 1 cycle.
- `out_ready` high while `out_valid`: transfer at that edge, IDLE after it. A new request can be accepted on the next edge, not the same edge.
- `out_ready` low: DONE holds indefinitely with all outputs stable.
- `in_ready` and `busy` are pure functions of state, with no combinational path from `in_valid`.
- Back-to-back throughput: one op per 34 cycles for iterative ops, 2 cycles for fast-path ops.

## Structure
- Shared package `ysyx_24080014_pkg` holds:
  - the `op` encoding constants (`MDU_MUL`…`MDU_REMU`);
  - the FSM state enum;
  - `XLEN`.
- One sub-module, `ysyx_24080014_mdu_iter`, is the per-cycle shift-add / shift-subtract datapath step (combinational). The top level owns the FSM, counter, sign fix-up and output registers.

## Test plan
- MUL 7 × 6 → `rd_data`=42, `out_valid` exactly 32 cycles after accept; `rd_out` equals the latched `rd_in`.
- MULH 32'hFFFF_FFFF × 32'hFFFF_FFFF → 0. MULHU with the same operands → 32'hFFFF_FFFE. MULHSU with the same operands → 32'hFFFF_FFFF.
- DIV −7 / 2 → 32'hFFFF_FFFD; REM −7 / 2 → 32'hFFFF_FFFF; DIVU 100 / 7 → 14; REMU 100 / 7 → 2.
- DIVU 5 / 0 → 32'hFFFF_FFFF. REM 5 / 0 → 5. DIV 32'h8000_0000 / −1 → 32'h8000_0000. All three have `out_valid` one cycle after accept.
- Hold `out_ready`=0 for 10 cycles in DONE → outputs unchanged, `in_ready`=0, a new `in_valid` is ignored. Raising `out_ready` → IDLE next edge.
- Assert `flush` at CALC cycle 15, then separately deassert `rst_n` mid-CALC → IDLE next edge, `out_valid` never asserted. A following MUL 3 × 3 returns 9 with normal latency.

Source files
------------

// File: rtl/ysyx_24080014_pkg.sv
// Shared definitions for the RV32M multiply/divide unit.
package ysyx_24080014_pkg;

  localparam int XLEN = 32;

  // funct3 encoding of the M-extension ops
  localparam logic [2:0] MDU_MUL    = 3'd0;
  localparam logic [2:0] MDU_MULH   = 3'd1;
  localparam logic [2:0] MDU_MULHSU = 3'd2;
  localparam logic [2:0] MDU_MULHU  = 3'd3;
  localparam logic [2:0] MDU_DIV    = 3'd4;
  localparam logic [2:0] MDU_DIVU   = 3'd5;
  localparam logic [2:0] MDU_REM    = 3'd6;
  localparam logic [2:0] MDU_REMU   = 3'd7;

  // Counter value during the final (32nd) iteration
  localparam logic [5:0] LAST_ITER = 6'd31;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/ysyx_24080014_mdu_iter.sv
// One combinational step of the iterative datapath.
// Multiply: {hi,lo} holds partial product / remaining multiplier; add opnd
//   when lo[0] is set, then shift the pair right by one.
// Divide: hi is the partial remainder, lo the dividend shifting out its MSB
//   while quotient bits shift in at the bottom (restoring division).
module ysyx_24080014_mdu_iter
  import ysyx_24080014_pkg::*;
(
  input  logic            is_div,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] opnd,
  output logic [XLEN-1:0] hi_nxt,
  output logic [XLEN-1:0] lo_nxt
);

  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic            div_ge;
  logic [XLEN-1:0] div_sub;

  // Compute both step flavours and select by operation class
  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    div_shift = {hi, lo[XLEN-1]};
    div_ge    = (div_shift >= {1'b0, opnd});
    // True difference is below the divisor, so 32 bits suffice
    div_sub   = div_shift[XLEN-1:0] - opnd;
    if (is_div) begin
      hi_nxt = div_ge ? div_sub : div_shift[XLEN-1:0];
      lo_nxt = {lo[XLEN-2:0], div_ge};
    end else begin
      hi_nxt = mul_sum[XLEN:1];
      lo_nxt = {mul_sum[0], lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/ysyx_24080014_mdu.sv
// Iterative RV32M multiply/divide unit: FSM, iteration counter, sign
// handling, divide fast paths and the held result registers.
//
// Handshake: a request transfers on a posedge where in_valid && in_ready;
// a result transfers on a posedge where out_valid && out_ready. in_ready,
// out_valid and busy depend only on state. flush overrides both handshakes.
module ysyx_24080014_mdu
  import ysyx_24080014_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] rd_data,
  output logic [4:0]      rd_out,
  output logic            busy,
  output mdu_state_e      state_dbg
);

  mdu_state_e state, state_nxt;

  logic [5:0]      cnt;
  logic [2:0]      op_q;
  logic [XLEN-1:0] hi_q, lo_q, opnd_q;
  logic            neg_a_q, neg_b_q;

  logic [XLEN-1:0] hi_nxt, lo_nxt;

  logic            accept;
  logic            a_signed, b_signed, neg_a, neg_b;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] special_res;

  logic [2*XLEN-1:0] prod, prod_f;
  logic [XLEN-1:0]   quo_f, rem_f, final_res;

  assign accept = (state == S_IDLE) && in_valid && !flush;

  // Operand signedness, magnitudes and divide special-case detection
  always_comb begin
    a_signed = (op == MDU_MULH) || (op == MDU_MULHSU) || (op == MDU_DIV) || (op == MDU_REM);
    b_signed = (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
    neg_a    = a_signed && rs1_data[XLEN-1];
    neg_b    = b_signed && rs2_data[XLEN-1];
    mag_a    = neg_a ? (~rs1_data + 1'b1) : rs1_data;
    mag_b    = neg_b ? (~rs2_data + 1'b1) : rs2_data;
    div_zero = op[2] && (rs2_data == '0);
    div_ovf  = ((op == MDU_DIV) || (op == MDU_REM)) &&
               (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);
    special  = div_zero || div_ovf;
    // op[1] separates REM/REMU from DIV/DIVU
    if (div_zero) special_res = op[1] ? rs1_data : '1;
    else          special_res = op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  ysyx_24080014_mdu_iter u_iter (
    .is_div (op_q[2]),
    .hi     (hi_q),
    .lo     (lo_q),
    .opnd   (opnd_q),
    .hi_nxt (hi_nxt),
    .lo_nxt (lo_nxt)
  );

  // Sign fix-up of the final iteration's output, selected by op
  always_comb begin
    prod   = {hi_nxt, lo_nxt};
    prod_f = (neg_a_q ^ neg_b_q) ? (~prod + 1'b1) : prod;
    quo_f  = (neg_a_q ^ neg_b_q) ? (~lo_nxt + 1'b1) : lo_nxt;
    rem_f  = neg_a_q ? (~hi_nxt + 1'b1) : hi_nxt;
    case (op_q)
      MDU_MUL:                        final_res = prod_f[XLEN-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU: final_res = prod_f[2*XLEN-1:XLEN];
      MDU_DIV, MDU_DIVU:              final_res = quo_f;
      default:                        final_res = rem_f;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; flush returns to IDLE from anywhere
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (in_valid) state_nxt = special ? S_DONE : S_CALC;
      S_CALC: if (cnt == LAST_ITER) state_nxt = S_DONE;
      S_DONE: if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (flush) state_nxt = S_IDLE;
  end

  // State-decoded outputs
  always_comb begin
    in_ready  = (state == S_IDLE);
    busy      = (state == S_CALC) || (state == S_DONE);
    out_valid = (state == S_DONE);
    state_dbg = state;
  end

  // Datapath: latch request, iterate, capture result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      op_q    <= MDU_MUL;
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      rd_data <= '0;
      rd_out  <= '0;
    end else if (accept) begin
      cnt     <= '0;
      op_q    <= op;
      hi_q    <= '0;
      lo_q    <= mag_a;
      opnd_q  <= mag_b;
      neg_a_q <= neg_a;
      neg_b_q <= neg_b;
      rd_out  <= rd_in;
      if (special) rd_data <= special_res;
    end else if ((state == S_CALC) && !flush) begin
      cnt  <= cnt + 6'd1;
      hi_q <= hi_nxt;
      lo_q <= lo_nxt;
      if (cnt == LAST_ITER) rd_data <= final_res;
    end
  end

endmodule

// File: tb/tb_ysyx_24080014_mdu.sv
// Directed self-checking bench for the multiply/divide unit.
module tb_ysyx_24080014_mdu;
  import ysyx_24080014_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [4:0]  rd_in;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] rd_data;
  logic [4:0]  rd_out;
  logic        busy;
  mdu_state_e  state_dbg;

  int n_cmp  = 0;
  int n_fail = 0;

  ysyx_24080014_mdu dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .rd_in     (rd_in),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rd_data   (rd_data),
    .rd_out    (rd_out),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request, wait for the result, check edge index, data, rd,
  // then consume it. exp_edge counts edges after the accept edge E0.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input int exp_edge);
    int n;
    in_valid = 1'b1; op = o; rs1_data = a; rs2_data = b; rd_in = rd;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    check({tag, " latency"}, n, exp_edge);
    check({tag, " data"}, rd_data, exp);
    check({tag, " rd"}, {27'd0, rd_out}, {27'd0, rd});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, " back_idle"}, {29'd0, out_valid, in_ready, busy}, 32'd2);
  endtask

  // Watch for a number of cycles and record whether out_valid ever rose
  task automatic watch_no_valid(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      seen = seen | out_valid;
    end
    check(tag, {31'd0, seen}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; op = 3'd0; rs1_data = '0; rs2_data = '0;
    rd_in = '0; flush = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;

    // Reset state
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset in_ready",  {31'd0, in_ready},  32'd1);
    check("reset busy",      {31'd0, busy},      32'd0);
    check("reset rd_data",   rd_data,            32'd0);
    check("reset rd_out",    {27'd0, rd_out},    32'd0);

    // Multiplies
    run_op("mul_7x6",     MDU_MUL,    32'd7,         32'd6,         5'd5,  32'd42,        32);
    run_op("mulh_m1m1",   MDU_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'h0,         32);
    run_op("mulhu_m1m1",  MDU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, 32);
    run_op("mulhsu_m1m1", MDU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, 32);
    run_op("mul_m1x2_rd0", MDU_MUL,   32'hFFFF_FFFF, 32'd2,         5'd0,  32'hFFFF_FFFE, 32);
    run_op("mulh_m3x5",   MDU_MULH,   32'hFFFF_FFFD, 32'd5,         5'd9,  32'hFFFF_FFFF, 32);

    // Divides
    run_op("div_m7d2",    MDU_DIV,    32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFD, 32);
    run_op("rem_m7d2",    MDU_REM,    32'hFFFF_FFF9, 32'd2,         5'd11, 32'hFFFF_FFFF, 32);
    run_op("divu_100d7",  MDU_DIVU,   32'd100,       32'd7,         5'd12, 32'd14,        32);
    run_op("remu_100d7",  MDU_REMU,   32'd100,       32'd7,         5'd13, 32'd2,         32);
    run_op("div_7dm2",    MDU_DIV,    32'd7,         32'hFFFF_FFFE, 5'd14, 32'hFFFF_FFFD, 32);
    run_op("rem_7dm2",    MDU_REM,    32'd7,         32'hFFFF_FFFE, 5'd15, 32'd1,         32);

    // Fast paths
    run_op("divu_5d0",    MDU_DIVU,   32'd5,         32'd0,         5'd16, 32'hFFFF_FFFF, 0);
    run_op("rem_5d0",     MDU_REM,    32'd5,         32'd0,         5'd17, 32'd5,         0);
    run_op("div_ovf",     MDU_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'h8000_0000, 0);
    run_op("rem_ovf",     MDU_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 32'd0,         0);
    run_op("div_5d0",     MDU_DIV,    32'd5,         32'd0,         5'd20, 32'hFFFF_FFFF, 0);

    // DONE held with out_ready low; new request ignored
    in_valid = 1'b1; op = MDU_MUL; rs1_data = 32'd3; rs2_data = 32'd5; rd_in = 5'd7;
    tick();
    op = MDU_DIVU; rs1_data = 32'd9; rs2_data = 32'd0; rd_in = 5'd21;
    repeat (32) tick();
    check("hold entered done", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold data",      rd_data,              32'd15);
      check("hold rd",        {27'd0, rd_out},      32'd7);
      check("hold valid",     {31'd0, out_valid},   32'd1);
      check("hold in_ready",  {31'd0, in_ready},    32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("hold release idle", {30'd0, state_dbg}, {30'd0, S_IDLE});
    check("hold release flags", {29'd0, out_valid, in_ready, busy}, 32'd2);

    // flush beats a simultaneous in_valid in IDLE
    in_valid = 1'b1; flush = 1'b1; op = MDU_MUL; rs1_data = 32'd2; rs2_data = 32'd2; rd_in = 5'd1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    check("flush_idle busy", {31'd0, busy}, 32'd0);

    // flush at CALC cycle 15
    in_valid = 1'b1; op = MDU_MUL; rs1_data = 32'd4; rs2_data = 32'd4; rd_in = 5'd2;
    tick();
    in_valid = 1'b0;
    repeat (14) tick();
    check("flush pre busy", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush flags", {29'd0, out_valid, in_ready, busy}, 32'd2);
    watch_no_valid("flush no result", 40);

    // reset mid-CALC
    in_valid = 1'b1; op = MDU_DIVU; rs1_data = 32'd50; rs2_data = 32'd3; rd_in = 5'd3;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst_mid flags",   {29'd0, out_valid, in_ready, busy}, 32'd2);
    check("rst_mid rd_data", rd_data,         32'd0);
    check("rst_mid rd_out",  {27'd0, rd_out}, 32'd0);
    watch_no_valid("rst_mid no result", 40);

    // Normal operation afterwards
    run_op("mul_3x3_after", MDU_MUL, 32'd3, 32'd3, 5'd4, 32'd9, 32);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
